// File: rtl/perf_monitor_if.sv
// Readout bus of the performance monitor: request/select in, registered response out.
// Ports: rd_req/rd_sel (master -> slave), rd_valid/rd_data (slave -> master).
// One response cycle per request, no stall path; the requester cannot be backpressured.
interface perf_monitor_if #(
  parameter int WIDTH = 32
);
  logic             rd_req;
  logic [1:0]       rd_sel;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;

  modport master (output rd_req, output rd_sel, input  rd_valid, input  rd_data);
  modport slave  (input  rd_req, input  rd_sel, output rd_valid, output rd_data);
endinterface

// File: rtl/perf_monitor.sv
// CPU performance counters (cycles, stalls, branch predictions, mispredictions) with a run FSM.
// Latency: counters update at the edge, readout data appears the cycle after rd_req.
// Backpressure: none; every rd_req gets exactly one rd_valid cycle, back-to-back allowed.
// Ports: input_clk, rst (sync active-low), en/stall/hlt/br_valid/br_miss/clr event inputs,
//        rd (readout bus, slave side), four counter outputs, ExecutedCount, halted.
module perf_monitor #(
  parameter int WIDTH = 32,
  parameter int SAT   = 1
) (
  input  logic             input_clk,
  input  logic             rst,
  input  logic             en,
  input  logic             stall,
  input  logic             hlt,
  input  logic             br_valid,
  input  logic             br_miss,
  input  logic             clr,
  perf_monitor_if.slave    rd,
  output logic [WIDTH-1:0] cycles_consumed,
  output logic [WIDTH-1:0] StallCount,
  output logic [WIDTH-1:0] BranchPredictionCount,
  output logic [WIDTH-1:0] BranchPredictionMissCount,
  output logic [WIDTH-1:0] ExecutedCount,
  output logic             halted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cyc_q, cyc_d;
  logic [WIDTH-1:0] stl_q, stl_d;
  logic [WIDTH-1:0] bp_q, bp_d;
  logic [WIDTH-1:0] miss_q, miss_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [WIDTH-1:0] sel_val;

  // Saturating or wrapping increment depending on SAT.
  function automatic logic [WIDTH-1:0] bump(input logic [WIDTH-1:0] v);
    if ((SAT != 0) && (&v)) begin
      return v;
    end
    return v + ONE;
  endfunction

  // Readout samples the registered counters, i.e. the value before this edge's update,
  // which is also what makes a read coinciding with clr return the pre-clear value.
  always_comb begin
    sel_val = cyc_q;
    case (rd.rd_sel)
      2'd0:    sel_val = cyc_q;
      2'd1:    sel_val = stl_q;
      2'd2:    sel_val = bp_q;
      default: sel_val = miss_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    stl_d      = stl_q;
    bp_d       = bp_q;
    miss_d     = miss_q;
    rd_valid_d = rd.rd_req;
    rd_data_d  = rd.rd_req ? sel_val : '0;

    if (clr) begin
      // Clear wins over any same-cycle increment and restarts the run.
      state_d = RUN;
      cyc_d   = '0;
      stl_d   = '0;
      bp_d    = '0;
      miss_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            state_d = RUN;
          end
        end
        RUN: begin
          // The halt cycle itself is not a consumed cycle, so stalls on it are dropped too,
          // keeping StallCount <= cycles_consumed. Branch resolution still counts.
          if (!hlt) begin
            cyc_d = bump(cyc_q);
            if (stall) begin
              stl_d = bump(stl_q);
            end
          end
          if (br_valid) begin
            bp_d = bump(bp_q);
            if (br_miss) begin
              miss_d = bump(miss_q);
            end
          end
          if (hlt) begin
            state_d = HALTED;
          end
        end
        HALTED: begin
          state_d = HALTED;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge input_clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cyc_q      <= '0;
      stl_q      <= '0;
      bp_q       <= '0;
      miss_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      stl_q      <= stl_d;
      bp_q       <= bp_d;
      miss_q     <= miss_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign cycles_consumed           = cyc_q;
  assign StallCount                = stl_q;
  assign BranchPredictionCount     = bp_q;
  assign BranchPredictionMissCount = miss_q;
  assign ExecutedCount             = cyc_q - stl_q;
  assign halted                    = (state_q == HALTED);
  assign rd.rd_valid               = rd_valid_q;
  assign rd.rd_data                = rd_data_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Bench for perf_monitor: a 32-bit instance driven from a vector table, plus two 4-bit
// instances (saturating and wrapping) sharing the same stimulus for the overflow sequence.
// Readout responses are matched against a queue of expected values filled at request time.
module tb_perf_monitor;

  logic        input_clk;
  logic        rst, en, stall, hlt, br_valid, br_miss, clr, rd_req;
  logic [1:0]  rd_sel;

  logic [31:0] cyc, stl, bp, miss, exe;
  logic        hd;
  logic [3:0]  s_cyc, s_stl, s_bp, s_miss, s_exe;
  logic        s_hd;
  logic [3:0]  w_cyc, w_stl, w_bp, w_miss, w_exe;
  logic        w_hd;

  perf_monitor_if #(.WIDTH(32)) rif ();
  perf_monitor_if #(.WIDTH(4))  rif_s ();
  perf_monitor_if #(.WIDTH(4))  rif_w ();

  assign rif.rd_req   = rd_req;
  assign rif.rd_sel   = rd_sel;
  assign rif_s.rd_req = rd_req;
  assign rif_s.rd_sel = rd_sel;
  assign rif_w.rd_req = rd_req;
  assign rif_w.rd_sel = rd_sel;

  perf_monitor #(.WIDTH(32), .SAT(1)) u_dut (
    .input_clk(input_clk), .rst(rst), .en(en), .stall(stall), .hlt(hlt),
    .br_valid(br_valid), .br_miss(br_miss), .clr(clr), .rd(rif.slave),
    .cycles_consumed(cyc), .StallCount(stl), .BranchPredictionCount(bp),
    .BranchPredictionMissCount(miss), .ExecutedCount(exe), .halted(hd)
  );

  perf_monitor #(.WIDTH(4), .SAT(1)) u_sat (
    .input_clk(input_clk), .rst(rst), .en(en), .stall(stall), .hlt(hlt),
    .br_valid(br_valid), .br_miss(br_miss), .clr(clr), .rd(rif_s.slave),
    .cycles_consumed(s_cyc), .StallCount(s_stl), .BranchPredictionCount(s_bp),
    .BranchPredictionMissCount(s_miss), .ExecutedCount(s_exe), .halted(s_hd)
  );

  perf_monitor #(.WIDTH(4), .SAT(0)) u_wrap (
    .input_clk(input_clk), .rst(rst), .en(en), .stall(stall), .hlt(hlt),
    .br_valid(br_valid), .br_miss(br_miss), .clr(clr), .rd(rif_w.slave),
    .cycles_consumed(w_cyc), .StallCount(w_stl), .BranchPredictionCount(w_bp),
    .BranchPredictionMissCount(w_miss), .ExecutedCount(w_exe), .halted(w_hd)
  );

  initial input_clk = 1'b0;
  always #5 input_clk = ~input_clk;

  typedef struct {
    logic        rs, en, st, hl, bv, bm, cl, rq;
    logic [1:0]  sel;
    logic [31:0] cyc, stl, bp, ms;
    logic        hd, rdv;
    logic [31:0] rdx;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] rd_exp_q[$];
  vec_t        tbl[28];

  function automatic vec_t v(logic rs, logic en_, logic st, logic hl, logic bv, logic bm,
                             logic cl, logic rq, logic [1:0] sel, int c, int s, int b,
                             int m, logic h, logic rdv, int rdx);
    vec_t r;
    r.rs = rs; r.en = en_; r.st = st; r.hl = hl; r.bv = bv; r.bm = bm; r.cl = cl;
    r.rq = rq; r.sel = sel;
    r.cyc = c; r.stl = s; r.bp = b; r.ms = m; r.hd = h; r.rdv = rdv; r.rdx = rdx;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t x);
    rst = x.rs; en = x.en; stall = x.st; hlt = x.hl; br_valid = x.bv;
    br_miss = x.bm; clr = x.cl; rd_req = x.rq; rd_sel = x.sel;
    if (x.rs && x.rq) rd_exp_q.push_back(x.rdx);
  endtask

  // Consume one readout response if present, and check rd_data is zero otherwise.
  task automatic check_readout(input logic exp_vld);
    logic [31:0] e;
    check("rd_valid", {31'd0, rif.rd_valid}, {31'd0, exp_vld});
    if (rif.rd_valid === 1'b1) begin
      if (rd_exp_q.size() == 0) begin
        check("rd_unexpected", 32'd1, 32'd0);
      end else begin
        e = rd_exp_q.pop_front();
        check("rd_data", rif.rd_data, e);
      end
    end else begin
      check("rd_data_idle", rif.rd_data, 32'd0);
    end
  endtask

  task automatic run_idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge input_clk);
    end
  endtask

  initial begin
    //           rs en st hl bv bm cl rq sel  cyc stl bp ms hd rdv rdx
    tbl[0]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0,   0,  0, 0, 0, 0, 0,  0);
    tbl[1]  = v(1, 0, 1, 0, 1, 0, 0, 0, 0,   0,  0, 0, 0, 0, 0,  0);
    tbl[2]  = v(1, 1, 1, 0, 1, 0, 0, 0, 0,   0,  0, 0, 0, 0, 0,  0);
    tbl[3]  = v(1, 0, 1, 0, 1, 0, 0, 0, 0,   1,  1, 1, 0, 0, 0,  0);
    tbl[4]  = v(1, 0, 0, 0, 1, 1, 0, 0, 0,   2,  1, 2, 1, 0, 0,  0);
    tbl[5]  = v(1, 0, 0, 0, 0, 1, 0, 0, 0,   3,  1, 2, 1, 0, 0,  0);
    tbl[6]  = v(1, 0, 0, 0, 1, 0, 0, 0, 0,   4,  1, 3, 1, 0, 0,  0);
    tbl[7]  = v(1, 0, 1, 0, 1, 0, 0, 0, 0,   5,  2, 4, 1, 0, 0,  0);
    tbl[8]  = v(1, 0, 0, 0, 1, 1, 0, 0, 0,   6,  2, 5, 2, 0, 0,  0);
    tbl[9]  = v(1, 0, 0, 0, 0, 1, 0, 0, 0,   7,  2, 5, 2, 0, 0,  0);
    tbl[10] = v(1, 0, 0, 0, 1, 0, 0, 0, 0,   8,  2, 6, 2, 0, 0,  0);
    tbl[11] = v(1, 0, 1, 0, 1, 0, 0, 0, 0,   9,  3, 7, 2, 0, 0,  0);
    tbl[12] = v(1, 0, 0, 0, 1, 0, 0, 0, 0,  10,  3, 8, 2, 0, 0,  0);
    tbl[13] = v(1, 0, 1, 1, 0, 0, 0, 0, 0,  10,  3, 8, 2, 1, 0,  0);
    tbl[14] = v(1, 1, 1, 0, 1, 1, 0, 1, 0,  10,  3, 8, 2, 1, 1, 10);
    tbl[15] = v(1, 0, 0, 0, 0, 0, 0, 1, 1,  10,  3, 8, 2, 1, 1,  3);
    tbl[16] = v(1, 0, 0, 0, 0, 0, 0, 1, 2,  10,  3, 8, 2, 1, 1,  8);
    tbl[17] = v(1, 0, 0, 0, 0, 0, 0, 1, 3,  10,  3, 8, 2, 1, 1,  2);
    tbl[18] = v(1, 0, 0, 0, 0, 0, 0, 0, 0,  10,  3, 8, 2, 1, 0,  0);
    tbl[19] = v(1, 0, 1, 0, 1, 0, 1, 1, 3,   0,  0, 0, 0, 0, 1,  2);
    tbl[20] = v(1, 0, 1, 0, 1, 1, 0, 1, 0,   1,  1, 1, 1, 0, 1,  0);
    tbl[21] = v(0, 1, 1, 0, 1, 0, 0, 1, 2,   0,  0, 0, 0, 0, 0,  0);
    tbl[22] = v(1, 0, 1, 0, 1, 0, 0, 0, 0,   0,  0, 0, 0, 0, 0,  0);
    tbl[23] = v(1, 1, 0, 0, 0, 0, 0, 0, 0,   0,  0, 0, 0, 0, 0,  0);
    tbl[24] = v(1, 0, 1, 0, 1, 1, 1, 0, 0,   0,  0, 0, 0, 0, 0,  0);
    tbl[25] = v(1, 0, 0, 0, 1, 0, 0, 0, 0,   1,  0, 1, 0, 0, 0,  0);
    tbl[26] = v(1, 0, 1, 1, 1, 1, 0, 0, 0,   1,  0, 2, 1, 1, 0,  0);
    tbl[27] = v(1, 1, 1, 0, 1, 0, 0, 0, 0,   1,  0, 2, 1, 1, 0,  0);

    for (int i = 0; i < 28; i++) begin
      drive(tbl[i]);
      @(negedge input_clk);
      check($sformatf("cycles[%0d]", i), cyc, tbl[i].cyc);
      check($sformatf("stalls[%0d]", i), stl, tbl[i].stl);
      check($sformatf("preds[%0d]", i), bp, tbl[i].bp);
      check($sformatf("misses[%0d]", i), miss, tbl[i].ms);
      check($sformatf("executed[%0d]", i), exe, tbl[i].cyc - tbl[i].stl);
      check($sformatf("halted[%0d]", i), {31'd0, hd}, {31'd0, tbl[i].hd});
      check_readout(tbl[i].rdv);
    end

    // Overflow: 4-bit counters, saturating vs wrapping, across the all-ones boundary.
    drive(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge input_clk);
    check("narrow_rst_sat", {28'd0, s_cyc}, 32'd0);
    check("narrow_rst_wrap", {28'd0, w_cyc}, 32'd0);
    drive(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge input_clk);
    run_idle(15);
    check("sat_at_15", {28'd0, s_cyc}, 32'd15);
    check("wrap_at_15", {28'd0, w_cyc}, 32'd15);
    run_idle(1);
    check("sat_at_16", {28'd0, s_cyc}, 32'd15);
    check("wrap_at_16", {28'd0, w_cyc}, 32'd0);
    run_idle(4);
    check("sat_at_20", {28'd0, s_cyc}, 32'd15);
    check("wrap_at_20", {28'd0, w_cyc}, 32'd4);
    check("wide_at_20", cyc, 32'd20);
    check("rd_queue_drained", rd_exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the width of every counter and of rd_data.
REQ-002 The block SHALL have parameter SAT, default 1; 1 means counters saturate at all-ones, 0 means they wrap modulo 2^WIDTH.
REQ-003 The block SHALL have port input_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset (rst==0 at a rising edge resets).
REQ-005 The block SHALL have port en, input, 1 bit: start-of-run qualifier from the CPU top.
REQ-006 The block SHALL have port stall, input, 1 bit: pipeline stall asserted by the stall detection unit this cycle.
REQ-007 The block SHALL have port hlt, input, 1 bit: halt instruction committed this cycle.
REQ-008 The block SHALL have port br_valid, input, 1 bit: a branch prediction was resolved this cycle.
REQ-009 The block SHALL have port br_miss, input, 1 bit: the resolved prediction was wrong; meaningful only with br_valid.
REQ-010 The block SHALL have port clr, input, 1 bit: synchronous clear of all counters.
REQ-011 The block SHALL have port rd_req, input, 1 bit: readout request.
REQ-012 The block SHALL have port rd_sel, input, 2 bits: readout select (0 cycles, 1 stalls, 2 predictions, 3 misses).
REQ-013 The block SHALL have port cycles_consumed, output, WIDTH: count of non-halt run cycles.
REQ-014 The block SHALL have port StallCount, output, WIDTH: count of stall cycles.
REQ-015 The block SHALL have port BranchPredictionCount, output, WIDTH: count of resolved predictions.
REQ-016 The block SHALL have port BranchPredictionMissCount, output, WIDTH: count of mispredictions.
REQ-017 The block SHALL have port ExecutedCount, output, WIDTH: cycles_consumed minus StallCount, combinational, modulo 2^WIDTH.
REQ-018 The block SHALL have port halted, output, 1 bit: high while the FSM is in state HALTED.
REQ-019 The block SHALL have ports rd_valid (output, 1 bit) and rd_data (output, WIDTH): the readout response.

Function
REQ-020 The block SHALL implement a three-state FSM with states IDLE, RUN and HALTED.
REQ-021 IDLE SHALL go to RUN at the first edge with en==1; that edge counts nothing.
REQ-022 RUN SHALL go to HALTED on an edge with hlt==1.
REQ-023 HALTED SHALL persist until reset or clr.
REQ-024 In RUN with hlt==0, cycles_consumed SHALL increment by 1 per edge.
REQ-025 In RUN with hlt==1, cycles_consumed SHALL NOT increment; the halt cycle is excluded.
REQ-026 In RUN, StallCount SHALL increment when stall==1 and hlt==0.
REQ-027 In RUN, BranchPredictionCount SHALL increment when br_valid==1, independent of hlt.
REQ-028 In RUN, BranchPredictionMissCount SHALL increment when br_valid==1 and br_miss==1.
REQ-029 br_miss with br_valid==0 SHALL be ignored.
REQ-030 In IDLE and HALTED, all counters SHALL hold their values.
REQ-031 With SAT==1, a counter at all-ones SHALL hold its value; with SAT==0 it SHALL wrap to 0.
REQ-032 Invariants: BranchPredictionMissCount <= BranchPredictionCount, and StallCount <= cycles_consumed.
REQ-033 clr==1 SHALL zero all four counters and force the state to RUN; any same-cycle increments SHALL be discarded.
REQ-034 rd_req==1 at edge N SHALL produce rd_valid==1 for exactly the cycle after edge N, with rd_data equal to the selected counter's value before edge N's update.
REQ-035 Back-to-back rd_req SHALL give one rd_valid cycle per request, with no bubble.
REQ-036 When rd_valid==0, rd_data SHALL be 0.
REQ-037 A read coinciding with clr SHALL return the pre-clear value.

Reset
REQ-038 On an edge with rst==0: state IDLE; all counters 0; halted 0; rd_valid 0; rd_data 0.
REQ-039 rst SHALL take priority over clr, en, hlt and rd_req; a pending read is dropped.
REQ-040 Reset asserted mid-run SHALL discard all counts.

Verification
REQ-041 Directed test: reset, en=1, 10 cycles with stall high on 3 of them, then hlt -> cycles_consumed=10, StallCount=3, ExecutedCount=7, halted=1.
REQ-042 Directed test: 8 br_valid pulses, br_miss set on 2 of them, plus 2 br_miss pulses without br_valid -> BranchPredictionCount=8, BranchPredictionMissCount=2.
REQ-043 Directed test: WIDTH=4, 20 run cycles -> SAT=1 gives cycles_consumed=15; SAT=0 gives cycles_consumed=4.
REQ-044 Directed test: in HALTED, rd_req with rd_sel=0,1,2,3 on consecutive cycles -> rd_valid high for 4 consecutive cycles, returning 10, 3, 8, 2 in order.
REQ-045 Directed test: clr asserted together with stall and br_valid -> all counters 0 at the next edge; a same-cycle read returns the old value.
REQ-046 Directed test: rst=0 asserted mid-run with rd_req=1 -> next cycle all outputs are 0, rd_valid=0 and state is IDLE.
